apb_gpio_irq: RTL and testbench
===============================

# apb_gpio_irq

Parametrised APB GPIO slave: per-pin direction, output and synchronised input registers, plus per-pin edge-triggered interrupts with a write-1-to-clear status register and a single level interrupt output. It sits on an APB select line driven by the APB master, replacing the fixed 32-bit direction/input/output GPIO. Pin count and synchroniser depth are parameters.

## Interface
- DATA_WIDTH, 32, APB data width (PWDATA/PRDATA)
- ADDRESS_WIDTH, 32, APB address width
- GPIO_WIDTH, 32, number of pins; 1..DATA_WIDTH; unused upper data bits read 0, writes ignored
- SYNC_STAGES, 2, input synchroniser flops per pin; >=2
- PCLK  input  1  clock; all state on rising edge
- PRESETn  input  1  asynchronous active-low reset
- PSEL  input  1  slave select
- PENABLE  input  1  access phase
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDRESS_WIDTH  register offset (full value decoded)
- PWDATA  input  DATA_WIDTH  write data
- PRDATA  output  DATA_WIDTH  read data
- PREADY  output  1  transfer complete
- PSLVERR  output  1  transfer error
- GPIO_INPUT  input  GPIO_WIDTH  asynchronous pad inputs
- GPIO_OUTPUT  output  GPIO_WIDTH  pad output values
- GPIO_OE  output  GPIO_WIDTH  pad output enables (1 = drive)
- IRQ  output  1  level interrupt, active high

## Operation
- Register map (PADDR value): 0 DIRECTION (RW, 1 = output), 1 INPUT (RO), 2 OUTPUT (RW), 3 IRQ_EN (RW), 4 IRQ_TYPE (RW, 1 = rising, 0 = falling), 5 IRQ_STATUS (R/W1C).
- Reset: all registers, sync chain and edge-history register cleared to 0; PRDATA=0, PREADY=0, PSLVERR=0, GPIO_OUTPUT=0, GPIO_OE=0, IRQ=0.
- GPIO_OE = DIRECTION; GPIO_OUTPUT = OUTPUT & DIRECTION (input-direction pins drive 0).
- INPUT read: bit i = synchronised pad i when DIRECTION[i]=0, else 0.
- Edge detect per pin: s = last sync stage, p = s delayed one cycle. Event when DIRECTION[i]=0 and (IRQ_TYPE[i] ? s&~p : ~s&p).
- IRQ_STATUS[i] sets on event only while IRQ_EN[i]=1; clears on write with PWDATA[i]=1. Same-cycle set and clear on one bit: set wins.
- IRQ = |(IRQ_STATUS & IRQ_EN). Clearing IRQ_EN masks IRQ but keeps pending status.
- Switching a pin to output stops new events; pending status retained.
- Errors: PADDR > 5, or write to INPUT -> PSLVERR=1, no state change, PRDATA=0.

## Timing
- Zero wait states: PREADY=1 exactly when PSEL&PENABLE, else 0.
- PRDATA and PSLVERR valid while PSEL&PENABLE; PRDATA=0 otherwise.
- Writes commit at the PCLK edge ending the access phase (PSEL&PENABLE&PWRITE); GPIO_OUTPUT/GPIO_OE change after that edge.
- Setup phase (PSEL&~PENABLE) changes no state.
- Pad change sampled at edge N appears in INPUT after edge N+SYNC_STAGES-1; IRQ_STATUS sets and IRQ rises after edge N+SYNC_STAGES.
- IRQ falls the cycle after the W1C access completes if no other enabled status bit is set.
- PRESETn asserted mid-transfer: all state clears immediately; the transfer is abandoned.

## Configuration
- GPIO_IRQ_EN defined: interrupt logic (IRQ_EN, IRQ_TYPE, IRQ_STATUS, edge detect) present as above.
- GPIO_IRQ_EN undefined: no interrupt flops; offsets 3-5 read 0, writes ignored with PSLVERR=0; IRQ tied 0. Offsets 0-2 and sync path unchanged.

## Test plan
- Reset: read offsets 0,2,3,4,5 -> all 0; GPIO_OE=0, IRQ=0; read offset 6 -> PSLVERR=1, PRDATA=0.
- Direction/output: write DIRECTION=0x0000FFFF, OUTPUT=0x12345678 -> GPIO_OE=0x0000FFFF, GPIO_OUTPUT=0x00005678; read back both exactly.
- Input: DIRECTION=0x0000FFFF, GPIO_INPUT=0xA5A5A5A5 -> INPUT reads 0xA5A50000 no earlier than SYNC_STAGES cycles after change.
- Rising IRQ: DIRECTION=0, IRQ_EN=0x1, IRQ_TYPE=0x1, pin0 0->1 -> IRQ high SYNC_STAGES+1 edges later, STATUS=0x1; write STATUS=0x1 -> IRQ low; pin0 1->0 -> no IRQ.
- Masking/conflict: IRQ_EN=0, falling edge on pin3 with IRQ_TYPE=0 -> STATUS stays 0; with IRQ_EN[3]=1, W1C of bit 3 in the same cycle as a new event -> STATUS[3] remains 1.
- Build without GPIO_IRQ_EN: edges on any pin -> IRQ stays 0; offset 5 reads 0, PSLVERR=0.

Source files
------------

// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: APB GPIO slave with direction/output/synchronised-input registers.
// Optional edge-triggered interrupts (IRQ_EN, IRQ_TYPE, IRQ_STATUS W1C, IRQ) are built
// only when the GPIO_IRQ_EN macro is defined; otherwise offsets 3-5 read 0 and IRQ is 0.
module apb_gpio_irq #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int GPIO_WIDTH    = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDRESS_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0]    PWDATA,
    output logic [DATA_WIDTH-1:0]    PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [GPIO_WIDTH-1:0]    GPIO_INPUT,
    output logic [GPIO_WIDTH-1:0]    GPIO_OUTPUT,
    output logic [GPIO_WIDTH-1:0]    GPIO_OE,
    output logic                     IRQ
);
    localparam logic [ADDRESS_WIDTH-1:0] A_DIR  = ADDRESS_WIDTH'(0);
    localparam logic [ADDRESS_WIDTH-1:0] A_IN   = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] A_OUT  = ADDRESS_WIDTH'(2);
    localparam logic [ADDRESS_WIDTH-1:0] A_EN   = ADDRESS_WIDTH'(3);
    localparam logic [ADDRESS_WIDTH-1:0] A_TYPE = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] A_STAT = ADDRESS_WIDTH'(5);

    logic                                 w_access;
    logic                                 w_wr;
    logic                                 w_err;
    logic [GPIO_WIDTH-1:0]                r_dir;
    logic [GPIO_WIDTH-1:0]                r_out;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;
    logic [GPIO_WIDTH-1:0]                w_sync;
    logic [GPIO_WIDTH-1:0]                w_en;
    logic [GPIO_WIDTH-1:0]                w_type;
    logic [GPIO_WIDTH-1:0]                w_stat;
    logic [GPIO_WIDTH-1:0]                w_rd;

    assign w_access = PSEL & PENABLE;
    assign w_wr     = w_access & PWRITE;
    assign w_err    = (PADDR > A_STAT) | (PWRITE & (PADDR == A_IN));
    assign w_sync   = r_sync[SYNC_STAGES-1];

    assign w_rd = (PADDR == A_DIR)  ? r_dir :
                  (PADDR == A_IN)   ? (w_sync & ~r_dir) :
                  (PADDR == A_OUT)  ? r_out :
                  (PADDR == A_EN)   ? w_en :
                  (PADDR == A_TYPE) ? w_type :
                  (PADDR == A_STAT) ? w_stat : '0;

    assign PREADY      = w_access;
    assign PSLVERR     = w_access & w_err;
    assign PRDATA      = (w_access & ~PWRITE & ~w_err) ? DATA_WIDTH'(w_rd) : '0;
    assign GPIO_OE     = r_dir;
    assign GPIO_OUTPUT = r_out & r_dir;

    // Pad synchroniser: shift raw pads through SYNC_STAGES flops
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], GPIO_INPUT};
    end

    // Direction and output registers, written at the end of the access phase
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_dir <= '0;
            r_out <= '0;
        end else if (w_wr) begin
            if (PADDR == A_DIR) r_dir <= PWDATA[GPIO_WIDTH-1:0];
            if (PADDR == A_OUT) r_out <= PWDATA[GPIO_WIDTH-1:0];
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] r_irq_en;
    logic [GPIO_WIDTH-1:0] r_irq_type;
    logic [GPIO_WIDTH-1:0] r_irq_stat;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [GPIO_WIDTH-1:0] w_event;
    logic [GPIO_WIDTH-1:0] w_clr;

    // Only input-direction, enabled pins can raise a new event
    assign w_event = ~r_dir & r_irq_en &
                     ((r_irq_type & w_sync & ~r_prev) | (~r_irq_type & ~w_sync & r_prev));
    assign w_clr   = (w_wr && PADDR == A_STAT) ? PWDATA[GPIO_WIDTH-1:0] : '0;

    // Interrupt config, edge history and W1C status (a new event beats a same-cycle clear)
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_irq_en   <= '0;
            r_irq_type <= '0;
            r_irq_stat <= '0;
            r_prev     <= '0;
        end else begin
            r_prev     <= w_sync;
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_event;
            if (w_wr && PADDR == A_EN)   r_irq_en   <= PWDATA[GPIO_WIDTH-1:0];
            if (w_wr && PADDR == A_TYPE) r_irq_type <= PWDATA[GPIO_WIDTH-1:0];
        end
    end

    assign w_en   = r_irq_en;
    assign w_type = r_irq_type;
    assign w_stat = r_irq_stat;
    assign IRQ    = |(r_irq_stat & r_irq_en);
`else
    assign w_en   = '0;
    assign w_type = '0;
    assign w_stat = '0;
    assign IRQ    = 1'b0;
`endif
endmodule

// File: tb/tb_apb_gpio_irq.sv
// tb_apb_gpio_irq: randomized APB/pad stimulus checked every cycle against a register-level model
module tb_apb_gpio_irq;
    localparam int S = 2;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] gin = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] gout;
    logic [31:0] goe;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit mon = 1'b0;

    apb_gpio_irq #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .GPIO_WIDTH(32), .SYNC_STAGES(S)) dut (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .GPIO_INPUT(gin), .GPIO_OUTPUT(gout), .GPIO_OE(goe), .IRQ(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers as plain values, synchronised pad = pad sampled S edges ago
    logic [31:0] m_dir, m_out, m_en, m_type, m_stat, m_ev;
    logic [31:0] ph [0:S];

    always_comb begin
        m_ev = '0;
        for (int i = 0; i < 32; i++)
            if (!m_dir[i] && m_en[i] &&
                (m_type[i] ? (ph[S-1][i] && !ph[S][i]) : (!ph[S-1][i] && ph[S][i])))
                m_ev[i] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dir <= '0; m_out <= '0; m_en <= '0; m_type <= '0; m_stat <= '0;
            for (int k = 0; k <= S; k++) ph[k] <= '0;
        end else begin
            ph[0] <= gin;
            for (int k = 1; k <= S; k++) ph[k] <= ph[k-1];
            m_stat <= (m_stat & ~((psel && penable && pwrite && paddr == 5 && IRQ_ON) ? pwdata : 32'h0)) | m_ev;
            if (psel && penable && pwrite) begin
                if (paddr == 0) m_dir <= pwdata;
                if (paddr == 2) m_out <= pwdata;
                if (paddr == 3 && IRQ_ON) m_en <= pwdata;
                if (paddr == 4 && IRQ_ON) m_type <= pwdata;
            end
        end
    end

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        case (a)
            0: return m_dir;
            1: return ph[S-1] & ~m_dir;
            2: return m_out;
            3: return m_en;
            4: return m_type;
            5: return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    logic c_acc, c_err;
    initial forever begin
        @(negedge clk);
        if (mon) begin
            c_acc = psel && penable;
            c_err = (paddr > 5) || (pwrite && paddr == 1);
            chk("pready", 32'(pready), 32'(c_acc));
            chk("pslverr", 32'(pslverr), 32'(c_acc && c_err));
            chk("prdata", prdata, (c_acc && !pwrite && !c_err) ? m_reg(paddr) : 32'h0);
            chk("gpio_oe", goe, m_dir);
            chk("gpio_out", gout, m_out & m_dir);
            chk("irq", 32'(irq), 32'(|(m_stat & m_en)));
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1 psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1 psel = 0; penable = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #1 psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1 penable = 1;
        @(negedge clk); d = prdata; e = pslverr;
        @(posedge clk); #1 psel = 0; penable = 0;
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp, input logic exp_e);
        logic [31:0] d;
        logic e;
        rd(a, d, e);
        chk(name, d, exp);
        chk({name, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, d;
        logic e;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        mon = 1'b1;
        chk("oe_rst", goe, 32'h0);
        chk("irq_rst", 32'(irq), 32'h0);
        rdchk("rst_dir", 0, 32'h0, 1'b0);
        rdchk("rst_out", 2, 32'h0, 1'b0);
        rdchk("rst_en", 3, 32'h0, 1'b0);
        rdchk("rst_type", 4, 32'h0, 1'b0);
        rdchk("rst_stat", 5, 32'h0, 1'b0);
        rdchk("bad_addr", 6, 32'h0, 1'b1);

        wr(0, 32'h0000FFFF);
        wr(2, 32'h12345678);
        chk("oe_lit", goe, 32'h0000FFFF);
        chk("out_lit", gout, 32'h00005678);
        rdchk("dir_rb", 0, 32'h0000FFFF, 1'b0);
        rdchk("out_rb", 2, 32'h12345678, 1'b0);
        wr(1, 32'hFFFFFFFF);
        rdchk("dir_after_badwr", 0, 32'h0000FFFF, 1'b0);

        gin = 32'hA5A5A5A5;
        idle(S + 1);
        rdchk("input_lit", 1, 32'hA5A50000, 1'b0);

        if (IRQ_ON) begin
            wr(0, 32'h0);
            gin = 32'h0;
            idle(S + 2);
            wr(3, 32'h1);
            wr(4, 32'h1);
            wr(5, 32'hFFFFFFFF);
            gin = 32'h1;
            repeat (S) @(posedge clk);
            #2 chk("irq_early", 32'(irq), 32'h0);
            @(posedge clk);
            #2 chk("irq_rise", 32'(irq), 32'h1);
            rdchk("stat_rise", 5, 32'h1, 1'b0);
            wr(5, 32'h1);
            chk("irq_w1c", 32'(irq), 32'h0);
            gin = 32'h0;
            idle(S + 3);
            chk("irq_no_fall", 32'(irq), 32'h0);
            rdchk("stat_no_fall", 5, 32'h0, 1'b0);

            wr(3, 32'h0);
            wr(4, 32'h0);
            gin = 32'h8;
            idle(S + 2);
            gin = 32'h0;
            idle(S + 2);
            rdchk("stat_masked", 5, 32'h0, 1'b0);
            wr(3, 32'h8);
            gin = 32'h8;
            idle(S + 2);
            gin = 32'h0;
            idle(S + 2);
            rdchk("stat_fall", 5, 32'h8, 1'b0);
            chk("irq_fall", 32'(irq), 32'h1);
            gin = 32'h8;
            idle(S + 2);
            gin = 32'h0;
            repeat (S - 1) @(posedge clk);
            #1 psel = 1; penable = 0; pwrite = 1; paddr = 5; pwdata = 32'h8;
            @(posedge clk); #1 penable = 1;
            @(posedge clk); #1 psel = 0; penable = 0;
            rdchk("stat_conflict", 5, 32'h8, 1'b0);
            wr(5, 32'h8);
            chk("irq_clear3", 32'(irq), 32'h0);
            wr(0, 32'h8);
            gin = 32'h8;
            idle(S + 2);
            gin = 32'h0;
            idle(S + 2);
            rdchk("stat_outpin", 5, 32'h0, 1'b0);
        end else begin
            wr(0, 32'h0);
            wr(3, 32'hFF);
            wr(4, 32'hFF);
            wr(5, 32'hFF);
            gin = 32'hFFFFFFFF;
            idle(S + 2);
            gin = 32'h0;
            idle(S + 2);
            chk("irq_off", 32'(irq), 32'h0);
            rdchk("stat_off", 5, 32'h0, 1'b0);
            rdchk("en_off", 3, 32'h0, 1'b0);
        end

        for (int i = 0; i < 600; i++) begin
            a = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h100;
            d = $urandom;
            if ($urandom_range(0, 2) == 0) gin = gin ^ ($urandom & $urandom);
            case ($urandom_range(0, 3))
                0: wr(a, d);
                1: rd(a, d, e);
                2: idle($urandom_range(1, 3));
                default: begin
                    @(posedge clk); #1 psel = 1; penable = 0; pwrite = 1'($urandom); paddr = a; pwdata = d;
                    @(posedge clk); #1 psel = 0;
                end
            endcase
        end

        wr(0, 32'hFFFF0000);
        @(posedge clk); #1 psel = 1; penable = 0; pwrite = 1; paddr = 0; pwdata = 32'hFFFFFFFF;
        @(posedge clk); #1 penable = 1;
        #2 rst_n = 1'b0;
        #1 chk("oe_async_rst", goe, 32'h0);
        chk("irq_async_rst", 32'(irq), 32'h0);
        psel = 0; penable = 0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rdchk("dir_after_rst", 0, 32'h0, 1'b0);
        chk("oe_after_rst", goe, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
